// File: rtl/sim_test_pkg.sv
// Shared types for the test watchdog: result codes, FSM states and the result record.
package sim_test_pkg;

  localparam int DEF_ID_W  = 8;
  localparam int DEF_CYC_W = 32;

  typedef enum logic [1:0] {
    RES_PASS    = 2'd0,
    RES_FAIL    = 2'd1,
    RES_TIMEOUT = 2'd2,
    RES_ABORT   = 2'd3
  } res_code_e;

  typedef enum logic {
    WD_IDLE = 1'b0,
    WD_RUN  = 1'b1
  } wd_state_e;

  // Record layout at the default widths; the watchdog packs {id, code, cycles} in this order.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    res_code_e            code;
    logic [DEF_CYC_W-1:0] cycles;
  } res_rec_t;

endpackage

// File: rtl/sim_result_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry while not empty.
module sim_result_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sim_test_watchdog.sv
// Test watchdog: times one test at a time and queues a result record when it ends.
//   state   | meaning
//   WD_IDLE | no test running, waiting for an accepted test_start
//   WD_RUN  | test running, elapsed counting, waiting for done/abort/timeout
module sim_test_watchdog
  import sim_test_pkg::*;
#(
  parameter int ID_W       = 8,
  parameter int CYC_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int STAT_W     = 16
) (
  input  logic              test_clk,
  input  logic              test_reset_n,
  input  logic              test_start,
  input  logic [ID_W-1:0]   test_id,
  input  logic [CYC_W-1:0]  timeout_cycles,
  input  logic              test_done,
  input  logic              test_pass,
  input  logic              test_abort,
  input  logic              clear_stats,
  output logic              busy,
  output logic              start_rej,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [1:0]        res_code,
  output logic [CYC_W-1:0]  res_cycles,
  output logic [STAT_W-1:0] tests_run,
  output logic [STAT_W-1:0] tests_passed,
  output logic [STAT_W-1:0] tests_failed
);

  localparam int REC_W = ID_W + 2 + CYC_W;

  wd_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [CYC_W-1:0]  timeout_q;
  logic [CYC_W-1:0]  elapsed_q, elapsed_d, elapsed_inc;
  logic [CYC_W:0]    elapsed_wide;
  logic              timeout_hit, accept, reject, push;
  res_code_e         code;
  logic [CYC_W-1:0]  rec_cycles;
  logic [REC_W-1:0]  rec_wr, rec_rd;
  logic              fifo_full, fifo_empty;
  logic [STAT_W-1:0] run_base, pass_base, fail_base;
  logic [STAT_W-1:0] run_d, pass_d, fail_d;

  // Widened sum keeps a saturated counter from ever wrapping onto the timeout value.
  assign elapsed_wide = {1'b0, elapsed_q} + (CYC_W+1)'(1);
  assign elapsed_inc  = (&elapsed_q) ? elapsed_q : elapsed_wide[CYC_W-1:0];
  assign timeout_hit  = (timeout_q != '0) && (elapsed_wide == {1'b0, timeout_q});

  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    accept     = 1'b0;
    reject     = 1'b0;
    push       = 1'b0;
    code       = RES_PASS;
    rec_cycles = elapsed_inc;
    case (state_q)
      WD_IDLE: begin
        if (test_start) begin
          if (fifo_full) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_d   = WD_RUN;
            elapsed_d = '0;
          end
        end
      end
      WD_RUN: begin
        reject    = test_start;
        elapsed_d = elapsed_inc;
        if (test_done) begin
          push = 1'b1;
          code = test_pass ? RES_PASS : RES_FAIL;
        end else if (test_abort) begin
          push = 1'b1;
          code = RES_ABORT;
        end else if (timeout_hit) begin
          push       = 1'b1;
          code       = RES_TIMEOUT;
          rec_cycles = timeout_q;
        end
        if (push) begin
          state_d   = WD_IDLE;
          elapsed_d = '0;
        end
      end
      default: state_d = WD_IDLE;
    endcase
  end

  always_comb begin
    run_base  = clear_stats ? '0 : tests_run;
    pass_base = clear_stats ? '0 : tests_passed;
    fail_base = clear_stats ? '0 : tests_failed;
    run_d     = (push && !(&run_base)) ? run_base + 1'b1 : run_base;
    pass_d    = (push && code == RES_PASS && !(&pass_base)) ? pass_base + 1'b1 : pass_base;
    fail_d    = (push && code != RES_PASS && !(&fail_base)) ? fail_base + 1'b1 : fail_base;
  end

  always_ff @(posedge test_clk or negedge test_reset_n) begin
    if (!test_reset_n) begin
      state_q      <= WD_IDLE;
      id_q         <= '0;
      timeout_q    <= '0;
      elapsed_q    <= '0;
      start_rej    <= 1'b0;
      tests_run    <= '0;
      tests_passed <= '0;
      tests_failed <= '0;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      start_rej    <= reject;
      tests_run    <= run_d;
      tests_passed <= pass_d;
      tests_failed <= fail_d;
      if (accept) begin
        id_q      <= test_id;
        timeout_q <= timeout_cycles;
      end
    end
  end

  assign busy   = (state_q == WD_RUN);
  assign rec_wr = {id_q, code, rec_cycles};

  sim_result_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (test_clk),
    .rst_n   (test_reset_n),
    .push    (push),
    .wr_data (rec_wr),
    .pop     (res_valid && res_ready),
    .rd_data (rec_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_valid  = !fifo_empty;
  assign res_id     = rec_rd[REC_W-1 -: ID_W];
  assign res_code   = rec_rd[CYC_W +: 2];
  assign res_cycles = rec_rd[CYC_W-1:0];

endmodule

// File: tb/tb_sim_test_watchdog.sv
// Directed and randomized bench for sim_test_watchdog against a cycle-count reference model.
module tb_sim_test_watchdog;
  import sim_test_pkg::*;

  logic        test_clk = 1'b0;
  logic        test_reset_n = 1'b0;
  logic        test_start = 1'b0;
  logic [7:0]  test_id = '0;
  logic [31:0] timeout_cycles = '0;
  logic        test_done = 1'b0;
  logic        test_pass = 1'b0;
  logic        test_abort = 1'b0;
  logic        clear_stats = 1'b0;
  logic        busy, start_rej, res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_id;
  logic [1:0]  res_code;
  logic [31:0] res_cycles;
  logic [15:0] tests_run, tests_passed, tests_failed;

  int total = 0;
  int bad = 0;
  int exp_run = 0, exp_pass = 0, exp_fail = 0;
  res_rec_t exp_q[$];

  sim_test_watchdog dut (
    .test_clk(test_clk), .test_reset_n(test_reset_n), .test_start(test_start),
    .test_id(test_id), .timeout_cycles(timeout_cycles), .test_done(test_done),
    .test_pass(test_pass), .test_abort(test_abort), .clear_stats(clear_stats),
    .busy(busy), .start_rej(start_rej), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_code(res_code), .res_cycles(res_cycles),
    .tests_run(tests_run), .tests_passed(tests_passed), .tests_failed(tests_failed)
  );

  always #5 test_clk = ~test_clk;

  task automatic tick();
    @(posedge test_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_run"}, 64'(tests_run), 64'(exp_run));
    chk({tag, "_passed"}, 64'(tests_passed), 64'(exp_pass));
    chk({tag, "_failed"}, 64'(tests_failed), 64'(exp_fail));
  endtask

  // ev: 0 none, 1 done, 2 abort, 3 done+abort; event driven during RUN cycle n (1-based).
  task automatic run_test(input logic [7:0] id, input int to, input int n, input int ev,
                          input bit p, input bit clr, input int rej_at);
    int end_c;
    int exp_end;
    res_rec_t r;
    end_c = -1;
    if (ev != 0 && (to == 0 || n <= to)) begin
      exp_end = n;
      r.code  = (ev == 2) ? RES_ABORT : (p ? RES_PASS : RES_FAIL);
    end else begin
      exp_end = to;
      r.code  = RES_TIMEOUT;
    end
    r.id = id;
    r.cycles = 32'(exp_end);
    test_start = 1'b1; test_id = id; timeout_cycles = 32'(to);
    tick();
    test_start = 1'b0; test_id = ~id;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_norej", 64'(start_rej), 64'd0);
    for (int c = 1; c <= 300; c++) begin
      if (c == n && ev != 0) begin
        test_done = (ev == 1 || ev == 3); test_abort = (ev == 2 || ev == 3);
        test_pass = p; clear_stats = clr;
      end
      if (c == rej_at) begin
        test_start = 1'b1; test_id = id + 8'd1;
      end
      tick();
      test_done = 1'b0; test_abort = 1'b0; clear_stats = 1'b0; test_start = 1'b0;
      if (c == rej_at) chk("run_rej", 64'(start_rej), 64'd1);
      if (!busy) begin
        end_c = c;
        break;
      end
    end
    chk("end_cycle", 64'(end_c), 64'(exp_end));
    if (clr) begin
      exp_run = 0; exp_pass = 0; exp_fail = 0;
    end
    exp_run++;
    if (r.code == RES_PASS) exp_pass++; else exp_fail++;
    exp_q.push_back(r);
    chk_stats("stats");
  endtask

  task automatic drain();
    res_rec_t r;
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!res_valid || exp_q.size() == 0) break;
      r = exp_q.pop_front();
      chk("rec_id", 64'(res_id), 64'(r.id));
      chk("rec_code", 64'(res_code), 64'(r.code));
      chk("rec_cycles", 64'(res_cycles), 64'(r.cycles));
      tick();
    end
    res_ready = 1'b0;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(res_valid), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_rej", 64'(start_rej), 64'd0);
    chk_stats("rst");
    tick();
    test_reset_n = 1'b1;
    tick();

    run_test(8'd5, 100, 10, 1, 1'b1, 1'b0, 0);
    drain();
    run_test(8'd7, 20, 0, 0, 1'b0, 1'b0, 0);
    run_test(8'd9, 4, 4, 3, 1'b1, 1'b0, 0);
    run_test(8'd9, 4, 4, 3, 1'b0, 1'b0, 0);
    run_test(8'd11, 1, 1, 0, 1'b0, 1'b0, 0);
    run_test(8'd12, 6, 3, 2, 1'b1, 1'b0, 0);
    drain();

    repeat (24) begin
      int to, n, ev;
      to = $urandom_range(0, 12);
      n  = $urandom_range(1, 15);
      ev = $urandom_range(0, 3);
      if (to == 0 && ev == 0) ev = 1;
      run_test(8'($urandom), to, n, ev, 1'($urandom), 1'b0, 0);
      if (exp_q.size() >= 6) drain();
    end
    drain();

    for (int t = 0; t < 8; t++) run_test(8'(8'd40 + t), 0, 2, 1, 1'b1, 1'b0, 0);
    test_start = 1'b1; test_id = 8'd99; timeout_cycles = 32'd3;
    tick();
    test_start = 1'b0;
    chk("full_rej", 64'(start_rej), 64'd1);
    chk("full_busy", 64'(busy), 64'd0);
    tick();
    chk("full_rej_end", 64'(start_rej), 64'd0);
    chk("full_busy2", 64'(busy), 64'd0);
    chk_stats("full_stats");
    drain();

    run_test(8'd3, 0, 6, 1, 1'b1, 1'b1, 2);
    chk("clr_run", 64'(tests_run), 64'd1);
    chk("clr_pass", 64'(tests_passed), 64'd1);
    chk("clr_fail", 64'(tests_failed), 64'd0);
    drain();

    run_test(8'd21, 3, 5, 0, 1'b0, 1'b0, 0);
    test_start = 1'b1; test_id = 8'd22; timeout_cycles = 32'd0;
    tick();
    test_start = 1'b0;
    repeat (1000) tick();
    chk("long_busy", 64'(busy), 64'd1);
    test_reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_run = 0; exp_pass = 0; exp_fail = 0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_rej", 64'(start_rej), 64'd0);
    chk_stats("mid_rst");
    tick();
    test_reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_test(8'd30, 0, 3, 1, 1'b0, 1'b0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sim_test_watchdog.md
SIM_TEST_WATCHDOG -- requirements
Module: sim_test_watchdog

Interface
REQ-001 Parameter ID_W, default 8, test identifier width.
REQ-002 Parameter CYC_W, default 32, cycle counter and timeout width.
REQ-003 Parameter FIFO_DEPTH, default 8, result FIFO entries (power of 2, >=2).
REQ-004 Parameter STAT_W, default 16, statistics counter width.
REQ-005 test_clk  in  1  sole clock, all logic on rising edge.
REQ-006 test_reset_n  in  1  asynchronous active-low reset.
REQ-007 test_start  in  1  single-cycle pulse to begin a test.
REQ-008 test_id  in  ID_W  test identifier, sampled with test_start.
REQ-009 timeout_cycles  in  CYC_W  timeout limit, sampled with test_start; 0 means no timeout.
REQ-010 test_done  in  1  single-cycle pulse marking test completion.
REQ-011 test_pass  in  1  verdict, sampled with test_done (1 = pass).
REQ-012 test_abort  in  1  single-cycle pulse that aborts the running test.
REQ-013 clear_stats  in  1  single-cycle pulse that zeroes the statistics counters.
REQ-014 busy  out  1  high while a test is running.
REQ-015 start_rej  out  1  one-cycle pulse when a test_start is rejected.
REQ-016 res_valid/res_ready  out/in  1/1  result stream handshake.
REQ-017 res_id/res_code/res_cycles  out  ID_W/2/CYC_W  result record.
REQ-018 tests_run/tests_passed/tests_failed  out  STAT_W each  statistics counters.

Function
REQ-019 FSM states: IDLE, RUN; busy = (state==RUN).
REQ-020 IDLE with test_start and FIFO not full: latch id and timeout, clear elapsed to 0, go to RUN next cycle.
REQ-021 Rejection cases, each pulsing start_rej for one cycle with no state change: test_start with FIFO full in IDLE; any test_start in RUN.
REQ-022 In RUN, elapsed increments by 1 every cycle; it saturates at all-ones.
REQ-023 In RUN, test_done pushes record {id, PASS or FAIL per test_pass, elapsed+1} and returns to IDLE.
REQ-024 In RUN, test_abort without test_done pushes {id, ABORT, elapsed+1} and returns to IDLE.
REQ-025 In RUN, when timeout_cycles!=0 and elapsed+1==timeout_cycles with no done/abort, push {id, TIMEOUT, timeout_cycles} and return to IDLE.
REQ-026 Priority in the same cycle: test_done > test_abort > timeout.
REQ-027 test_done and test_abort in IDLE are ignored.
REQ-028 res_code encoding: PASS=0, FAIL=1, TIMEOUT=2, ABORT=3.
REQ-029 Result FIFO is show-ahead: res_valid = !empty; pop occurs when res_valid && res_ready. The start-time full check guarantees every push has room.
REQ-030 On each push: tests_run increments by 1; tests_passed increments on PASS; tests_failed increments on FAIL, TIMEOUT or ABORT. All counters saturate at all-ones.
REQ-031 clear_stats coincident with a push: counters take 0 plus that push's increment.

Reset
REQ-032 Assertion of test_reset_n low sets: state IDLE, FIFO empty, elapsed 0, all statistics 0, busy 0, start_rej 0, res_valid 0.
REQ-033 Reset mid-test discards the running test and pushes no record.

Structure
REQ-034 Package sim_test_pkg holds res_code_e (2-bit enum), wd_state_e, and the result record struct.
REQ-035 Sub-module sim_result_fifo implements a parameterized show-ahead synchronous FIFO with full/empty outputs.

Verification
REQ-036 Sequence: start id=5, timeout=100; test_done with pass=1 at the 10th cycle in RUN -> record {5, PASS, 10}; tests_run=1, tests_passed=1.
REQ-037 Sequence: start id=7, timeout=20; no done -> after 20 RUN cycles, record {7, TIMEOUT, 20}; tests_failed=1; busy falls.
REQ-038 Sequence: start id=9, timeout=4; done and abort in the same cycle as the 4th RUN cycle -> record {9, PASS/FAIL per test_pass, 4}.
REQ-039 Sequence: run 8 tests with res_ready=0, then start a 9th -> start_rej pulses once and busy stays 0. Raise res_ready -> 8 records drain in order.
REQ-040 Sequence: test_start while in RUN -> start_rej=1, latched id unchanged. clear_stats during a PASS push -> tests_run=1, tests_passed=1.
REQ-041 Sequence: start with timeout=0, run 1000 cycles, then assert test_reset_n low -> no record, all outputs return to their reset values.
